// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b one bit per cycle, LSB first, with unsigned borrow and signed overflow.
// Latency: handshake in cycle 0, SHIFT in cycles 1..WIDTH, result valid from cycle WIDTH+1 (one op per WIDTH+2 cycles).
// Backpressure: the result is held stable in HOLD until out_ready; new operands are refused until then.
// Ports: clk/rst (sync, active-high); in_valid/in_ready + a/b operand handshake;
//        out_valid/out_ready + diff/borrow/overflow result handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] diff_r;
  logic             a_msb;
  logic             b_msb;
  logic             br;
  logic             borrow_r;
  logic             overflow_r;
  logic [CW-1:0]    cnt;

  logic             a_i;
  logic             b_i;
  logic             bit_d;
  logic             br_next;
  logic             last_bit;
  logic             accept;
  logic             done;

  // Handshake qualifiers; rst masks both so nothing is accepted or
  // presented while reset is asserted.
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == HOLD) && !rst;
  assign accept    = in_valid && in_ready;
  assign done      = out_valid && out_ready;

  assign diff     = diff_r;
  assign borrow   = borrow_r;
  assign overflow = overflow_r;

  // One full-subtractor slice on the current LSBs of the operand shifters.
  always_comb begin
    a_i      = a_sh[0];
    b_i      = b_sh[0];
    bit_d    = a_i ^ b_i ^ br;
    br_next  = (~a_i & b_i) | (~a_i & br) | (b_i & br);
    last_bit = (state == SHIFT) && (cnt == LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)   state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = HOLD;
      HOLD:    if (done)     state_next = IDLE;
      default:               state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh       <= '0;
      b_sh       <= '0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      br         <= 1'b0;
      cnt        <= '0;
      diff_r     <= '0;
      borrow_r   <= 1'b0;
      overflow_r <= 1'b0;
    end else if (accept) begin
      // Result registers are left alone so the previous result survives in IDLE.
      a_sh  <= a;
      b_sh  <= b;
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
      br    <= 1'b0;
      cnt   <= '0;
    end else if (state == SHIFT) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      br     <= br_next;
      cnt    <= cnt + 1'b1;
      // New bit enters at the MSB; after WIDTH shifts bit 0 sits in diff[0].
      diff_r <= {bit_d, diff_r[WIDTH-1:1]};
      if (last_bit) begin
        // bit_d is the result MSB here; signed overflow when operand signs
        // differ and the result sign disagrees with the minuend.
        borrow_r   <= br_next;
        overflow_r <= (a_msb ^ b_msb) & (bit_d ^ a_msb);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor (WIDTH = 8): directed vectors with literal
// expectations plus a cycle-level reference model checked every cycle.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow;
  logic         overflow;

  int n_checks = 0;
  int n_fail   = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phase 0 = idle, 1 = busy computing, 2 = result presented.
  int           m_phase = 0;
  int           m_timer = 0;
  logic [W-1:0] m_diff;
  logic         m_borrow;
  logic         m_ovf;

  always begin
    @(negedge clk);
    chk("model_in_ready",  32'(in_ready),  32'((m_phase == 0) && !rst));
    chk("model_out_valid", 32'(out_valid), 32'((m_phase == 2) && !rst));
    if (m_phase == 2 && !rst) begin
      chk("model_diff",     32'(diff),     32'(m_diff));
      chk("model_borrow",   32'(borrow),   32'(m_borrow));
      chk("model_overflow", 32'(overflow), 32'(m_ovf));
    end
    @(posedge clk);
    if (rst) begin
      m_phase = 0;
    end else if (m_phase == 0) begin
      if (in_valid) begin
        int sa;
        int sb;
        int sr;
        sa       = int'($signed(a));
        sb       = int'($signed(b));
        sr       = sa - sb;
        m_diff   = W'(int'(a) - int'(b));
        m_borrow = (a < b);
        m_ovf    = (sr > 127) || (sr < -128);
        m_phase  = 1;
        m_timer  = W;
      end
    end else if (m_phase == 1) begin
      m_timer--;
      if (m_timer == 0) m_phase = 2;
    end else if (out_ready) begin
      m_phase = 0;
    end
  end

  // ---------------- directed helpers ----------------
  // Entered and left at posedge+1.
  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y,
                    input logic [W-1:0] ed, input logic eb, input logic eo,
                    input int hold_cycles, input string tag);
    int n;
    in_valid = 1'b1; a = x; b = y;
    @(negedge clk);
    chk({tag, "_accept_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (out_valid) begin
        n = i;
        break;
      end
    end
    chk({tag, "_latency"},  32'(n),        32'(W + 1));
    chk({tag, "_diff"},     32'(diff),     32'(ed));
    chk({tag, "_borrow"},   32'(borrow),   32'(eb));
    chk({tag, "_overflow"}, 32'(overflow), 32'(eo));
    for (int k = 0; k < hold_cycles; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; a = W'($urandom); b = W'($urandom);
      @(negedge clk);
      chk({tag, "_bp_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_bp_ready"}, 32'(in_ready),  32'd0);
      chk({tag, "_bp_diff"},  32'(diff),      32'(ed));
      chk({tag, "_bp_flags"}, 32'({borrow, overflow}), 32'({eb, eo}));
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_ready"}, 32'(in_ready),  32'd1);
    chk({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic expect_quiet(input int cycles, input string tag);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk({tag, "_no_out_valid"}, 32'(seen), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [W-1:0] rd [2];
    logic         rb [2];
    int           hs_cyc [2];
    int           n_hs;
    int           nres;
    logic         hs_now;

    rst = 1'b1; in_valid = 1'b1; a = 8'h12; b = 8'h34; out_ready = 1'b0;
    @(negedge clk);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("reset_diff",  32'(diff), 32'd0);
    chk("reset_flags", 32'({borrow, overflow}), 32'd0);
    chk("reset_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    expect_quiet(12, "rst_with_valid");

    op(8'h2D, 8'h1A, 8'h13, 1'b0, 1'b0, 0, "v2d_1a");
    op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 0, "v00_01");
    op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 0, "v80_01");
    op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 0, "v7f_ff");
    op(8'h55, 8'h55, 8'h00, 1'b0, 1'b0, 0, "v55_55");
    op(8'hC3, 8'h5A, 8'h69, 1'b0, 1'b1, 5, "backpressure");

    // Abort during the 4th SHIFT cycle.
    in_valid = 1'b1; a = 8'hAA; b = 8'h11;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("abort_rst_ready", 32'(in_ready),  32'd0);
    chk("abort_rst_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_diff",  32'(diff), 32'd0);
    chk("abort_flags", 32'({borrow, overflow}), 32'd0);
    chk("abort_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    expect_quiet(12, "abort");
    op(8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, 0, "v10_20");

    // Back-to-back with out_ready tied high.
    in_valid = 1'b1; a = 8'h03; b = 8'h01; out_ready = 1'b1;
    n_hs = 0; nres = 0;
    hs_cyc[0] = 0; hs_cyc[1] = 0;
    rd[0] = '0; rd[1] = '0; rb[0] = 1'b0; rb[1] = 1'b0;
    for (int c = 0; c < 60 && nres < 2; c++) begin
      @(negedge clk);
      if (out_valid) begin
        rd[nres] = diff;
        rb[nres] = borrow;
        nres++;
      end
      hs_now = in_ready && in_valid;
      @(posedge clk);
      if (hs_now && n_hs < 2) begin
        hs_cyc[n_hs] = c;
        n_hs++;
      end
      #1;
      if (n_hs == 1) begin a = 8'h01; b = 8'h03; end
      if (n_hs == 2) in_valid = 1'b0;
    end
    out_ready = 1'b0;
    chk("b2b_results", 32'(nres), 32'd2);
    chk("b2b_gap",     32'(hs_cyc[1] - hs_cyc[0]), 32'(W + 2));
    chk("b2b_diff0",   32'(rd[0]), 32'h02);
    chk("b2b_borrow0", 32'(rb[0]), 32'd0);
    chk("b2b_diff1",   32'(rd[1]), 32'hFE);
    chk("b2b_borrow1", 32'(rb[1]), 32'd1);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
